// File: rtl/input_conditioner.sv
// Per-bit two-flop synchroniser, consecutive-sample debouncer, edge pulses and sticky rise flags.
// A clean input step reaches level/pulse/flag outputs after DEBOUNCE_CYCLES+2 rising edges.
module input_conditioner #(
  parameter int WIDTH           = 9,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] evt_clr,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] evt_flags,
  output logic             evt_any
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] flags_q, flags_d;
  logic             any_q, any_d;

  // Any sample agreeing with the debounced level restarts that bit's count.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    flags_d = (flags_q & ~evt_clr) | rise_d;
    any_d   = |flags_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      flags_q <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      flags_q <= flags_d;
      any_q   <= any_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign evt_flags  = flags_q;
  assign evt_any    = any_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Table-driven bench for input_conditioner at DEBOUNCE_CYCLES=4, with hand-written reset sequences.
module tb_input_conditioner;

  typedef struct packed {
    logic [8:0] lvl;
    logic [8:0] rise;
    logic [8:0] fall;
    logic [8:0] flg;
    logic       any;
  } out_t;

  typedef struct {
    logic [8:0] pin;
    logic [8:0] clr;
    int         reps;
    out_t       exp;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [8:0] pin_in;
  logic [8:0] evt_clr;
  logic [8:0] level_out;
  logic [8:0] rise_pulse;
  logic [8:0] fall_pulse;
  logic [8:0] evt_flags;
  logic       evt_any;

  int   total = 0;
  int   bad   = 0;
  out_t exp_q[$];
  vec_t vecs[$];

  input_conditioner #(.WIDTH(9), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .pin_in     (pin_in),
    .evt_clr    (evt_clr),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .evt_flags  (evt_flags),
    .evt_any    (evt_any)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic out_t mk(input logic [8:0] lvl, input logic [8:0] rise,
                              input logic [8:0] fall, input logic [8:0] flg, input logic any);
    out_t o;
    o.lvl  = lvl;
    o.rise = rise;
    o.fall = fall;
    o.flg  = flg;
    o.any  = any;
    return o;
  endfunction

  task automatic add(input logic [8:0] pin, input logic [8:0] clr, input int reps, input out_t e);
    vec_t v;
    v.pin  = pin;
    v.clr  = clr;
    v.reps = reps;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  // Pop the oldest expectation and compare it against the current outputs.
  task automatic check_now(input string nm);
    out_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, nothing expected", nm);
    end else begin
      e = exp_q.pop_front();
      if (level_out !== e.lvl || rise_pulse !== e.rise || fall_pulse !== e.fall ||
          evt_flags !== e.flg || evt_any !== e.any) begin
        bad++;
        $display("FAIL %s: got lvl=%h rise=%h fall=%h flg=%h any=%b, want lvl=%h rise=%h fall=%h flg=%h any=%b",
                 nm, level_out, rise_pulse, fall_pulse, evt_flags, evt_any,
                 e.lvl, e.rise, e.fall, e.flg, e.any);
      end
    end
  endtask

  task automatic step(input logic [8:0] p, input logic [8:0] c, input out_t e, input string nm);
    pin_in  = p;
    evt_clr = c;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_now(nm);
  endtask

  initial begin
    out_t zero;
    zero = mk(9'h000, 9'h000, 9'h000, 9'h000, 1'b0);

    // clean press on bit 0: flips on the 6th edge after the change
    add(9'h001, 9'h000, 5, mk(9'h000, 9'h000, 9'h000, 9'h000, 1'b0));
    add(9'h001, 9'h000, 1, mk(9'h001, 9'h001, 9'h000, 9'h001, 1'b1));
    add(9'h001, 9'h000, 2, mk(9'h001, 9'h000, 9'h000, 9'h001, 1'b1));
    // 3-cycle glitch on bit 3 is rejected
    add(9'h009, 9'h000, 3, mk(9'h001, 9'h000, 9'h000, 9'h001, 1'b1));
    add(9'h001, 9'h000, 6, mk(9'h001, 9'h000, 9'h000, 9'h001, 1'b1));
    // clear bit 0 with no new rise
    add(9'h001, 9'h001, 1, mk(9'h001, 9'h000, 9'h000, 9'h000, 1'b0));
    add(9'h001, 9'h000, 2, mk(9'h001, 9'h000, 9'h000, 9'h000, 1'b0));
    // bit 8 bounces 1,0,1,0 then holds 1
    add(9'h101, 9'h000, 1, mk(9'h001, 9'h000, 9'h000, 9'h000, 1'b0));
    add(9'h001, 9'h000, 1, mk(9'h001, 9'h000, 9'h000, 9'h000, 1'b0));
    add(9'h101, 9'h000, 1, mk(9'h001, 9'h000, 9'h000, 9'h000, 1'b0));
    add(9'h001, 9'h000, 1, mk(9'h001, 9'h000, 9'h000, 9'h000, 1'b0));
    add(9'h101, 9'h000, 5, mk(9'h001, 9'h000, 9'h000, 9'h000, 1'b0));
    add(9'h101, 9'h000, 1, mk(9'h101, 9'h100, 9'h000, 9'h100, 1'b1));
    add(9'h101, 9'h000, 2, mk(9'h101, 9'h000, 9'h000, 9'h100, 1'b1));
    // bit 8 released: fall pulse, flag stays
    add(9'h001, 9'h000, 5, mk(9'h101, 9'h000, 9'h000, 9'h100, 1'b1));
    add(9'h001, 9'h000, 1, mk(9'h001, 9'h000, 9'h100, 9'h100, 1'b1));
    add(9'h001, 9'h000, 2, mk(9'h001, 9'h000, 9'h000, 9'h100, 1'b1));
    // bit 0 released, then re-pressed with a clear landing on the rise edge
    add(9'h000, 9'h000, 5, mk(9'h001, 9'h000, 9'h000, 9'h100, 1'b1));
    add(9'h000, 9'h000, 1, mk(9'h000, 9'h000, 9'h001, 9'h100, 1'b1));
    add(9'h001, 9'h000, 5, mk(9'h000, 9'h000, 9'h000, 9'h100, 1'b1));
    add(9'h001, 9'h101, 1, mk(9'h001, 9'h001, 9'h000, 9'h001, 1'b1));
    add(9'h001, 9'h000, 1, mk(9'h001, 9'h000, 9'h000, 9'h001, 1'b1));
    // clearing already-clear bits leaves bit 0 alone
    add(9'h001, 9'h1FE, 1, mk(9'h001, 9'h000, 9'h000, 9'h001, 1'b1));
    // bits 1 and 2 together
    add(9'h007, 9'h000, 5, mk(9'h001, 9'h000, 9'h000, 9'h001, 1'b1));
    add(9'h007, 9'h000, 1, mk(9'h007, 9'h006, 9'h000, 9'h007, 1'b1));
    add(9'h007, 9'h000, 1, mk(9'h007, 9'h000, 9'h000, 9'h007, 1'b1));

    reset   = 1'b0;
    pin_in  = 9'h000;
    evt_clr = 9'h000;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(zero);
    check_now("reset_held");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(9'h000, 9'h000, zero, "idle");

    for (int v = 0; v < vecs.size(); v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        step(vecs[v].pin, vecs[v].clr, vecs[v].exp, $sformatf("vec%0d_r%0d", v, r));
      end
    end

    // pending change on bit 4 discarded by a reset after 3 edges
    for (int i = 0; i < 3; i++)
      step(9'h017, 9'h000, mk(9'h007, 9'h000, 9'h000, 9'h007, 1'b1), "pend4");
    #1 reset = 1'b0;
    #1;
    exp_q.push_back(zero);
    check_now("midcount_async_clear");
    step(9'h017, 9'h000, zero, "midcount_held");
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step(9'h017, 9'h000, zero, $sformatf("post_rst_e%0d", i + 1));
    step(9'h017, 9'h000, mk(9'h017, 9'h017, 9'h000, 9'h017, 1'b1), "post_rst_rise");
    step(9'h017, 9'h000, mk(9'h017, 9'h000, 9'h000, 9'h017, 1'b1), "post_rst_hold");

    // asynchronous reset with every pin high
    step(9'h1FF, 9'h000, mk(9'h017, 9'h000, 9'h000, 9'h017, 1'b1), "pre_reset_all");
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(zero);
    check_now("async_reset_all");
    step(9'h1FF, 9'h000, zero, "reset_all_held");
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Synchronises, debounces and edge-detects the board switch/button inputs before they reach the MCU top-level `fpga_in` port. Each bit gets a two-flop synchroniser, an independent consecutive-sample debounce counter, one-cycle rise/fall pulses and a sticky rise-event flag with write-one-to-clear. `level_out` connects directly to `MCU_Top.fpga_in`. The event flags let firmware poll for presses without missing short ones.

## Interface
- `WIDTH`, default 9: number of input bits; matches `fpga_in[8:0]`.
- `DEBOUNCE_CYCLES`, default 65536: consecutive synchronised samples that must disagree with the debounced level before the level flips. Must be ≥2. Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- `clk`, input, 1: system clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `pin_in`, input, WIDTH: raw, asynchronous board inputs.
- `evt_clr`, input, WIDTH: per-bit write-one-to-clear for `evt_flags`; synchronous to `clk`.
- `level_out`, output, WIDTH: debounced level; drives MCU `fpga_in`.
- `rise_pulse`, output, WIDTH: one-cycle pulse per bit when `level_out` goes 0→1.
- `fall_pulse`, output, WIDTH: one-cycle pulse per bit when `level_out` goes 1→0.
- `evt_flags`, output, WIDTH: sticky per-bit rise events.
- `evt_any`, output, 1: OR of `evt_flags`; registered.

## Operation
- **Reset.** While `reset` is 0, all state clears asynchronously: synchroniser flops, counters, `level_out`, `rise_pulse`, `fall_pulse`, `evt_flags` and `evt_any` are all 0.
- **Synchroniser.** `s1 <= pin_in`, then `s2 <= s1`. Only `s2` is used downstream.
- **Debounce, per bit.** Each bit has two states: STABLE (`cnt == 0`) and COUNTING (`cnt > 0`).
  - If `s2 == level_out[i]`: `cnt <= 0`. This applies in either state, so any agreeing sample aborts a pending change.
  - If `s2 != level_out[i]` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - If `s2 != level_out[i]` and `cnt == DEBOUNCE_CYCLES-1`: `level_out[i] <= s2` and `cnt <= 0`.
  - The counter never exceeds `DEBOUNCE_CYCLES-1` and never wraps.
- **Edge pulses.** These are registered in the same edge that flips `level_out[i]`. `rise_pulse[i]` is 1 for exactly that one cycle when the new level is 1. `fall_pulse[i]` behaves the same way when the new level is 0. Otherwise both are 0.
- **Event flags, per bit.** The update uses the next-cycle rise condition, so the flag sets in the same edge as the pulse.
  - `evt_flags[i] <= (evt_flags[i] & ~evt_clr[i]) | rise_next[i]`.
  - If a set and a clear occur in the same cycle, the set wins.
  - Clearing an already-clear bit has no effect.
- **`evt_any`** is the OR of the next-state `evt_flags`, registered. It is always consistent with `evt_flags` in the same cycle.
- **Bit independence.** Bits are fully independent; simultaneous transitions on several bits are each handled on their own timeline.

## Timing
- **Clean step.** Raw `pin_in` changes before edge E0 and then holds.
  - `s2` reflects the change after edge E1.
  - `level_out`, the pulse and the flag update at edge E(DEBOUNCE_CYCLES+1).
  - Total latency is DEBOUNCE_CYCLES+2 rising edges.
- **Glitch rejection.** A `s2` excursion lasting ≤DEBOUNCE_CYCLES−1 cycles never changes `level_out`, and its counter returns to 0.
- **Bounce.** Each return of `s2` to the current level restarts the count from 0.
- **Reset mid-count.** The pending change is discarded. After `reset` deasserts, an input held at 1 needs the full DEBOUNCE_CYCLES+2 edges, then produces a `rise_pulse` and sets its flag, because `level_out` restarts at 0.
- **Output paths.** All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
Run with `DEBOUNCE_CYCLES=4`, `WIDTH=9`.
1. **Reset values.** Assert `reset=0` mid-simulation with `pin_in=9'h1FF` → all outputs read 0 immediately, without waiting for a clock edge.
2. **Clean press.** `pin_in[0]` goes 0→1 before edge 0 and holds → `level_out` becomes 9'h001 after edge 5, `rise_pulse` is 9'h001 for one cycle only, `evt_flags` is 9'h001, `evt_any` is 1.
3. **Glitch.** `pin_in[3]` is high for 3 clock cycles, then low → `level_out`, `rise_pulse` and `evt_flags` stay 0 throughout.
4. **Bounce, then release.** `pin_in[8]` toggles 1,0,1,0 on alternate cycles, then holds 1 → one `rise_pulse[8]` exactly 6 edges after the last toggle. Then hold low → `fall_pulse[8]` after 6 edges, and `evt_flags[8]` stays 1.
5. **Clear vs. set.**
   - Pulse `evt_clr=9'h001` while bit 0 is set and no new rise → `evt_flags[0]` is 0 next cycle and `evt_any` is 0.
   - Repeat with `evt_clr[0]` coinciding with a new rise on bit 0 → `evt_flags[0]` stays 1.
6. **Simultaneous bits and reset mid-count.**
   - Raise bits 1 and 2 on the same cycle → both rise together at edge 5.
   - Separately, assert reset after 3 edges of a pending change on bit 4 and hold `pin_in[4]=1` → `level_out[4]` reaches 1 only 6 edges after reset release.
